// File: rtl/multi_acc_if.sv
// -----------------------------------------------------------------------------
// multi_acc_if
//   Bundles the partial-product input stream and the result output stream of
//   multi_acc into one interface.
//
//   Input stream (from the multiplier):
//     in_vld, in_data[15:0], in_last -> block ; in_rdy <- block
//     acc_clr                         -> block  (discard in-progress group)
//   Result stream (to the consumer):
//     res_vld, res_data[ACC_W-1:0], res_ovf, res_cnt[7:0] <- block
//     res_rdy -> block
//   Status:
//     busy <- block
//
//   slave  : the accumulator side (multi_acc itself)
//   master : the environment driving beats and consuming results
// -----------------------------------------------------------------------------
interface multi_acc_if #(
  parameter int ACC_W = 24
);
  logic             in_vld;
  logic [15:0]      in_data;
  logic             in_last;
  logic             in_rdy;
  logic             acc_clr;
  logic             res_vld;
  logic             res_rdy;
  logic [ACC_W-1:0] res_data;
  logic             res_ovf;
  logic [7:0]       res_cnt;
  logic             busy;

  modport slave (
    input  in_vld, in_data, in_last, acc_clr, res_rdy,
    output in_rdy, res_vld, res_data, res_ovf, res_cnt, busy
  );

  modport master (
    output in_vld, in_data, in_last, acc_clr, res_rdy,
    input  in_rdy, res_vld, res_data, res_ovf, res_cnt, busy
  );
endinterface

// File: rtl/multi_acc.sv
// -----------------------------------------------------------------------------
// multi_acc
//   Sums a stream of signed 16-bit partial products into an ACC_W-bit
//   accumulator. A beat flagged in_last closes its group: the group sum, a
//   sticky overflow flag and the beat count (saturating at 255) are pushed
//   into an OBUF_DEPTH-entry output FIFO drained with a valid/ready handshake.
//   A full FIFO deasserts in_rdy, backpressuring the multiplier.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-high reset
//     bus  - multi_acc_if.slave (beat input, result output, busy)
//
//   Parameters:
//     ACC_W      - accumulator/result width (>= 17)
//     SAT        - 1: clamp on overflow, 0: two's-complement wrap
//     OBUF_DEPTH - output FIFO entries (power of 2, >= 2)
// -----------------------------------------------------------------------------
module multi_acc #(
  parameter int ACC_W      = 24,
  parameter int SAT        = 1,
  parameter int OBUF_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  multi_acc_if.slave bus
);

  localparam int PTR_W = $clog2(OBUF_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Group state
  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [7:0]       cnt;

  // Output FIFO
  logic [ACC_W-1:0] data_mem [OBUF_DEPTH];
  logic             ovf_mem  [OBUF_DEPTH];
  logic [7:0]       cnt_mem  [OBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             fifo_full;
  logic             fifo_empty;
  logic             beat_acc;
  logic             push;
  logic             pop;

  logic [ACC_W:0]   sum_wide;
  logic             beat_ovf;
  logic [ACC_W-1:0] sum;
  logic [7:0]       cnt_inc;
  logic             ovf_grp;

  assign fifo_full  = (count == (PTR_W+1)'(OBUF_DEPTH));
  assign fifo_empty = (count == '0);

  // in_rdy depends only on registered occupancy and acc_clr, so a pop while
  // full frees a slot for beats on the following cycle.
  assign bus.in_rdy = ~fifo_full & ~bus.acc_clr;
  assign beat_acc   = bus.in_vld & bus.in_rdy;
  assign push       = beat_acc & bus.in_last;
  assign pop        = ~fifo_empty & bus.res_rdy;

  // One extra bit catches signed overflow: the top two bits differ exactly
  // when the true sum does not fit in ACC_W bits.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W-15){bus.in_data[15]}}, bus.in_data};
    beat_ovf = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    sum      = sum_wide[ACC_W-1:0];
    if ((SAT != 0) && beat_ovf) begin
      sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // In IDLE acc/cnt/ovf are already zero, so the same sum/cnt_inc/ovf_grp
  // serve both the first beat of a group and later beats.
  assign cnt_inc = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
  assign ovf_grp = ovf | beat_ovf;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (bus.acc_clr) begin
      state <= ST_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else if (beat_acc) begin
      if (bus.in_last) begin
        state <= ST_IDLE;
        acc   <= '0;
        ovf   <= 1'b0;
        cnt   <= '0;
      end else begin
        state <= ST_ACCUM;
        acc   <= sum;
        ovf   <= ovf_grp;
        cnt   <= cnt_inc;
      end
    end
  end

  // Pointers wrap naturally because OBUF_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  // NOTE: the FIFO storage is not reset; an entry is only visible once the
  // occupancy count says it was written, and the outputs below are forced to
  // zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= sum;
      ovf_mem[wr_ptr]  <= ovf_grp;
      cnt_mem[wr_ptr]  <= cnt_inc;
    end
  end

  assign bus.res_vld  = ~fifo_empty;
  assign bus.res_data = fifo_empty ? '0    : data_mem[rd_ptr];
  assign bus.res_ovf  = fifo_empty ? 1'b0  : ovf_mem[rd_ptr];
  assign bus.res_cnt  = fifo_empty ? 8'h00 : cnt_mem[rd_ptr];
  assign bus.busy     = (state == ST_ACCUM) | ~fifo_empty;

endmodule

// File: tb/tb_multi_acc.sv
// -----------------------------------------------------------------------------
// tb_multi_acc
//   Self-checking bench for multi_acc. The main instance (ACC_W=24, SAT=1,
//   OBUF_DEPTH=2) is compared every cycle against a reference model that keeps
//   the group sum as a plain integer, clamps it to the 24-bit signed range and
//   holds completed results in a queue. Two ACC_W=17 instances (SAT=1 and
//   SAT=0) cover the narrow-width overflow cases with fixed expected values.
// -----------------------------------------------------------------------------
module tb_multi_acc;

  localparam int     DEPTH  = 2;
  localparam longint SUM_MAX = (64'sd1 <<< 23) - 1;
  localparam longint SUM_MIN = -(64'sd1 <<< 23);

  logic clk;
  logic rst;

  multi_acc_if #(.ACC_W(24)) bus ();
  multi_acc_if #(.ACC_W(17)) b17s ();
  multi_acc_if #(.ACC_W(17)) b17w ();

  multi_acc #(.ACC_W(24), .SAT(1), .OBUF_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  multi_acc #(.ACC_W(17), .SAT(1), .OBUF_DEPTH(2)) dut17_sat (
    .clk (clk),
    .rst (rst),
    .bus (b17s)
  );

  multi_acc #(.ACC_W(17), .SAT(0), .OBUF_DEPTH(2)) dut17_wrap (
    .clk (clk),
    .rst (rst),
    .bus (b17w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  typedef struct packed {
    logic [23:0] data;
    logic        ovf;
    logic [7:0]  cnt;
  } res_t;

  res_t   exp_q[$];
  longint g_sum;
  bit     g_ovf;
  int     g_cnt;
  bit     g_open;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    g_sum  = 0;
    g_ovf  = 1'b0;
    g_cnt  = 0;
    g_open = 1'b0;
  endfunction

  function automatic void model_beat(input logic [15:0] d, input logic last);
    longint s;
    res_t   r;
    s = g_sum + longint'($signed(d));
    if (s > SUM_MAX) begin
      s     = SUM_MAX;
      g_ovf = 1'b1;
    end else if (s < SUM_MIN) begin
      s     = SUM_MIN;
      g_ovf = 1'b1;
    end
    g_cnt = (g_cnt < 255) ? g_cnt + 1 : 255;
    if (last) begin
      r.data = s[23:0];
      r.ovf  = g_ovf;
      r.cnt  = g_cnt[7:0];
      exp_q.push_back(r);
      g_sum  = 0;
      g_ovf  = 1'b0;
      g_cnt  = 0;
      g_open = 1'b0;
    end else begin
      g_sum  = s;
      g_open = 1'b1;
    end
  endfunction

  // One clock cycle on the main instance: drive inputs at the falling edge,
  // check outputs against the model, then advance the model at the rising
  // edge. Returns at the next falling edge.
  task automatic beat(input logic vld, input logic [15:0] d, input logic last,
                      input logic clr, input logic rdy);
    bit exp_rdy;
    bit acc_now;
    bit pop_now;
    bus.in_vld  = vld;
    bus.in_data = d;
    bus.in_last = last;
    bus.acc_clr = clr;
    bus.res_rdy = rdy;
    #1;
    exp_rdy = (exp_q.size() < DEPTH) && !clr;
    check("in_rdy", 32'(bus.in_rdy), 32'(exp_rdy));
    check("res_vld", 32'(bus.res_vld), 32'(exp_q.size() != 0));
    check("busy", 32'(bus.busy), 32'(g_open || exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("head_data", 32'(bus.res_data), 32'(exp_q[0].data));
      check("head_ovf", 32'(bus.res_ovf), 32'(exp_q[0].ovf));
      check("head_cnt", 32'(bus.res_cnt), 32'(exp_q[0].cnt));
    end else begin
      check("empty_data", 32'(bus.res_data), 32'h0);
    end
    acc_now = vld && exp_rdy;
    pop_now = (exp_q.size() != 0) && rdy;
    @(posedge clk);
    if (pop_now) void'(exp_q.pop_front());
    if (clr) begin
      g_sum  = 0;
      g_ovf  = 1'b0;
      g_cnt  = 0;
      g_open = 1'b0;
    end else if (acc_now) begin
      model_beat(d, last);
    end
    @(negedge clk);
  endtask

  // Watchdog: the sequence below is bounded, this only guards against a hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();

    bus.in_vld = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.acc_clr = 1'b0; bus.res_rdy = 1'b0;
    b17s.in_vld = 1'b0; b17s.in_data = '0; b17s.in_last = 1'b0;
    b17s.acc_clr = 1'b0; b17s.res_rdy = 1'b0;
    b17w.in_vld = 1'b0; b17w.in_data = '0; b17w.in_last = 1'b0;
    b17w.acc_clr = 1'b0; b17w.res_rdy = 1'b0;

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_rdy", 32'(bus.in_rdy), 32'h1);
    check("rst_res_vld", 32'(bus.res_vld), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_res_data", 32'(bus.res_data), 32'h0);
    check("rst_res_ovf", 32'(bus.res_ovf), 32'h0);
    check("rst_res_cnt", 32'(bus.res_cnt), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // ACC_W=17 overflow: 0x7FFF x3 then 0x0000(last), result held at head
    for (int i = 0; i < 4; i++) begin
      b17s.in_vld  = 1'b1; b17w.in_vld  = 1'b1;
      b17s.in_data = (i < 3) ? 16'h7FFF : 16'h0000;
      b17w.in_data = (i < 3) ? 16'h7FFF : 16'h0000;
      b17s.in_last = (i == 3); b17w.in_last = (i == 3);
      @(posedge clk);
      @(negedge clk);
    end
    b17s.in_vld = 1'b0; b17w.in_vld = 1'b0;
    check("sat17_vld", 32'(b17s.res_vld), 32'h1);
    check("sat17_data", 32'(b17s.res_data), 32'h0FFFF);
    check("sat17_ovf", 32'(b17s.res_ovf), 32'h1);
    check("sat17_cnt", 32'(b17s.res_cnt), 32'h4);
    check("wrap17_vld", 32'(b17w.res_vld), 32'h1);
    check("wrap17_data", 32'(b17w.res_data), 32'h17FFD);
    check("wrap17_ovf", 32'(b17w.res_ovf), 32'h1);
    check("wrap17_cnt", 32'(b17w.res_cnt), 32'h4);

    // Basic two-beat group: 5 + 10
    beat(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 16'h000A, 1'b1, 1'b0, 1'b1);
    check("tp1_vld", 32'(bus.res_vld), 32'h1);
    check("tp1_data", 32'(bus.res_data), 32'h00000F);
    check("tp1_cnt", 32'(bus.res_cnt), 32'h2);
    check("tp1_ovf", 32'(bus.res_ovf), 32'h0);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("tp1_busy_after_pop", 32'(bus.busy), 32'h0);

    // Signed sums
    beat(1'b1, 16'hFFF8, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    check("neg_data", 32'(bus.res_data), 32'hFFFFFB);
    check("neg_cnt", 32'(bus.res_cnt), 32'h2);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
    check("min16_data", 32'(bus.res_data), 32'hFF8000);
    check("min16_cnt", 32'(bus.res_cnt), 32'h1);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("min16_idle", 32'(bus.busy), 32'h0);

    // Backpressure: fill the FIFO, hold beat 3, then drain in order
    beat(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    check("bp_full_rdy", 32'(bus.in_rdy), 32'h0);
    beat(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);  // pops 1 while full
    check("bp_rdy_recovers", 32'(bus.in_rdy), 32'h1);
    check("bp_head2", 32'(bus.res_data), 32'h000002);
    beat(1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);  // push 3 and pop 2 together
    check("bp_head3", 32'(bus.res_data), 32'h000003);
    check("bp_vld3", 32'(bus.res_vld), 32'h1);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // acc_clr discards the in-progress group, FIFO entry untouched
    beat(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 16'h0020, 1'b0, 1'b0, 1'b0);
    beat(1'b1, 16'h0040, 1'b0, 1'b1, 1'b0);
    beat(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("clr_head_kept", 32'(bus.res_data), 32'h000055);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("clr_data", 32'(bus.res_data), 32'h000001);
    check("clr_cnt", 32'(bus.res_cnt), 32'h1);
    check("clr_ovf", 32'(bus.res_ovf), 32'h0);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Long positive group: accumulator clamps and the count saturates
    for (int i = 0; i < 300; i++) beat(1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("sat24_data", 32'(bus.res_data), 32'h7FFFFF);
    check("sat24_ovf", 32'(bus.res_ovf), 32'h1);
    check("sat24_cnt", 32'(bus.res_cnt), 32'hFF);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      beat($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) beat(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset with a full FIFO
    beat(1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 16'h0006, 1'b0, 1'b0, 1'b0);
    bus.in_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_res_vld", 32'(bus.res_vld), 32'h0);
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_res_data", 32'(bus.res_data), 32'h0);
    check("arst_in_rdy", 32'(bus.in_rdy), 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    beat(1'b1, 16'h0007, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", 32'(bus.res_data), 32'h000007);
    check("post_rst_cnt", 32'(bus.res_cnt), 32'h1);
    beat(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
